char_buf_writer: RTL and testbench
==================================

CHAR_BUF_WRITER -- requirements
Module: char_buf_writer

Interface
REQ-001 SHALL provide parameter LENGTH, default 11, meaning number of character cells per text line (1..255).
REQ-002 SHALL provide ports: clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL provide ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL provide ports: in_data  in  8  ASCII byte from source.
REQ-005 SHALL provide ports: in_valid  in  1  in_data valid.
REQ-006 SHALL provide ports: in_ready  out  1  block accepts byte this cycle.
REQ-007 SHALL provide ports: vsync  in  1  frame sync level from VGA timing.
REQ-008 SHALL provide ports: rd_addr  in  8  display cell index from renderer.
REQ-009 SHALL provide ports: rd_code  out  6  glyph index of cell rd_addr.
REQ-010 SHALL provide ports: cursor  out  8  next shadow write position.
REQ-011 SHALL provide ports: overflow  out  1  sticky: printable byte dropped at full line.

Function
REQ-012 SHALL hold two LENGTH x 6-bit arrays: shadow (written by input) and display (read by renderer).
REQ-013 SHALL transfer a byte only when in_valid and in_ready are both high in the same cycle.
REQ-014 SHALL map bytes: 0x20 -> 0; '0'..'9' -> 1..10; 'a'..'z' and 'A'..'Z' -> 11..36; any other non-control byte -> 37.
REQ-015 SHALL, on accepted printable byte with cursor < LENGTH, write mapped code to shadow[cursor] and increment cursor next cycle.
REQ-016 SHALL, on accepted printable byte with cursor == LENGTH, drop it, hold cursor, set overflow.
REQ-017 SHALL, on accepted 0x08, decrement cursor and write 0 at the new cursor if cursor > 0; no effect if cursor == 0.
REQ-018 SHALL, on accepted 0x0C, enter CLEAR; write 0 to shadow[0..LENGTH-1], one cell per cycle; cursor = 0 on exit.
REQ-019 SHALL, on accepted 0x0A, enter WAIT_VS (commit request).
REQ-020 SHALL ignore all other control bytes (< 0x20 or 0x7F), accepting them with no state change.
REQ-021 SHALL implement states IDLE, CLEAR, WAIT_VS, COPY; in_ready = 1 only in IDLE.
REQ-022 SHALL detect vsync rising edge as vsync high with previous-cycle vsync low (one register stage).
REQ-023 SHALL, in WAIT_VS, move to COPY on the first vsync rising edge detected in a cycle after entering WAIT_VS.
REQ-024 SHALL, in COPY, copy shadow[i] to display[i] for i = 0..LENGTH-1, one cell per cycle (LENGTH cycles).
REQ-025 SHALL, after COPY, set cursor = 0, clear overflow, and return to IDLE; shadow content is retained.
REQ-026 SHALL, after CLEAR, return to IDLE after exactly LENGTH cycles.
REQ-027 SHALL register rd_code one cycle after rd_addr: rd_code = display[rd_addr], or 0 if rd_addr >= LENGTH.
REQ-028 SHALL keep the read path independent of the state machine; rd_code is valid in every state.
REQ-029 SHALL leave display unmodified in IDLE, CLEAR, and WAIT_VS.

Reset
REQ-030 SHALL, on rst_n low, asynchronously set state = IDLE, cursor = 0, overflow = 0, rd_code = 0, vsync history = 0, and all shadow and display cells = 0.
REQ-031 SHALL, on reset asserted mid-CLEAR or mid-COPY, abort the operation with no partial state retained.
REQ-032 SHALL have in_ready = 1 in the first cycle after rst_n deasserts.

Verification
REQ-033 SHALL cover "hello world" + 0x0A, then a vsync pulse -> after LENGTH copy cycles, rd_addr 0..10 returns 18,15,22,22,25,0,33,25,28,22,14; cursor = 0.
REQ-034 SHALL cover 12 printable bytes with no newline -> cursor = 11, overflow = 1, shadow[10] holds byte 11; after commit, overflow = 0.
REQ-035 SHALL cover "ab" + 0x08 + 0x08 + 0x08 -> cursor = 0, shadow[0..1] = 0; the third backspace has no effect.
REQ-036 SHALL cover 0x0A with vsync already high and held high -> remains in WAIT_VS with in_ready = 0; commit occurs only on the next rising edge.
REQ-037 SHALL cover 0x0C after filled line -> in_ready low for LENGTH cycles, all shadow cells 0; display unchanged until next commit.
REQ-038 SHALL cover reset pulse during COPY -> all rd_code reads = 0, state IDLE, in_ready = 1.

Source files
------------

// File: rtl/char_buf_writer.sv
// char_buf_writer
//   Double-buffered text line writer. Bytes from a source are mapped to
//   glyph codes and written into a shadow line. A newline requests a commit,
//   which copies the shadow line into the display line on the next vsync
//   rising edge. Form feed clears the shadow line. The renderer reads the
//   display line through a registered read port that works in every state.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_data   in   8-bit ASCII byte
//   in_valid  in   in_data valid
//   in_ready  out  byte accepted this cycle (high only in IDLE)
//   vsync     in   frame sync level
//   rd_addr   in   display cell index
//   rd_code   out  glyph code of cell rd_addr, one cycle later
//   cursor    out  next shadow write position
//   overflow  out  sticky flag: printable byte dropped at full line
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | accept bytes, write shadow, move cursor
// S_CLEAR   | zero shadow cells 0..LENGTH-1, one per cycle
// S_WAIT_VS | commit pending, wait for vsync rising edge
// S_COPY    | copy shadow cells into display, one per cycle
module char_buf_writer #(
  parameter int LENGTH = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       vsync,
  input  logic [7:0] rd_addr,
  output logic [5:0] rd_code,
  output logic [7:0] cursor,
  output logic       overflow
);

  localparam int              AW   = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [7:0]      LEN8 = 8'(LENGTH);
  localparam logic [AW-1:0]   LAST = AW'(LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_VS,
    S_COPY
  } state_t;

  state_t        state;
  logic [5:0]    shadow  [LENGTH];
  logic [5:0]    display [LENGTH];
  logic [AW-1:0] idx;
  logic          vsync_q;

  logic          vs_rise;
  logic          accept;
  logic          is_ctrl;
  logic [5:0]    code;
  logic [AW-1:0] cur_idx;
  logic [AW-1:0] cur_m1_idx;

  // Space -> 0, digits -> 1..10, letters (either case) -> 11..36,
  // everything else printable (including bytes >= 0x80) -> 37.
  function automatic logic [5:0] map_code(input logic [7:0] b);
    logic [5:0] c;
    c = 6'd37;
    if (b == 8'h20)
      c = 6'd0;
    else if (b >= 8'h30 && b <= 8'h39)
      c = 6'(b - 8'h2F);
    else if (b >= 8'h61 && b <= 8'h7A)
      c = 6'(b - 8'h56);
    else if (b >= 8'h41 && b <= 8'h5A)
      c = 6'(b - 8'h36);
    return c;
  endfunction

  always_comb begin
    vs_rise    = vsync & ~vsync_q;
    accept     = in_valid & in_ready;
    is_ctrl    = (in_data < 8'h20) || (in_data == 8'h7F);
    code       = map_code(in_data);
    cur_idx    = cursor[AW-1:0];
    cur_m1_idx = cur_idx - AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      in_ready <= 1'b1;
      cursor   <= 8'd0;
      overflow <= 1'b0;
      idx      <= '0;
      vsync_q  <= 1'b0;
      for (int i = 0; i < LENGTH; i++) begin
        shadow[i]  <= 6'd0;
        display[i] <= 6'd0;
      end
    end else begin
      vsync_q <= vsync;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!is_ctrl) begin
              if (cursor < LEN8) begin
                shadow[cur_idx] <= code;
                cursor          <= cursor + 8'd1;
              end else begin
                overflow <= 1'b1;
              end
            end else begin
              case (in_data)
                8'h08: begin
                  if (cursor != 8'd0) begin
                    cursor             <= cursor - 8'd1;
                    shadow[cur_m1_idx] <= 6'd0;
                  end
                end
                8'h0C: begin
                  state    <= S_CLEAR;
                  in_ready <= 1'b0;
                  idx      <= '0;
                end
                8'h0A: begin
                  state    <= S_WAIT_VS;
                  in_ready <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end

        S_CLEAR: begin
          shadow[idx] <= 6'd0;
          if (idx == LAST) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            cursor   <= 8'd0;
          end else begin
            idx <= idx + AW'(1);
          end
        end

        // vsync_q is already high if vsync was high on entry, so a level
        // that was high before the request never counts as an edge.
        S_WAIT_VS: begin
          if (vs_rise) begin
            state <= S_COPY;
            idx   <= '0;
          end
        end

        S_COPY: begin
          display[idx] <= shadow[idx];
          if (idx == LAST) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            cursor   <= 8'd0;
            overflow <= 1'b0;
          end else begin
            idx <= idx + AW'(1);
          end
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Read port is decoupled from the FSM; it sees display updates from COPY
  // one cycle after they land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_code <= 6'd0;
    else if (rd_addr < LEN8)
      rd_code <= display[rd_addr[AW-1:0]];
    else
      rd_code <= 6'd0;
  end

endmodule

// File: tb/tb_char_buf_writer.sv
// tb_char_buf_writer
//   Directed stimulus for char_buf_writer. Expected read results and status
//   values are queued by the stimulus process; a negedge monitor pops and
//   compares them when the DUT presents the corresponding output.
module tb_char_buf_writer;

  localparam int LENGTH = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       vsync = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic [5:0] rd_code;
  logic [7:0] cursor;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string name;
    int    which;
    int    exp;
  } st_t;

  typedef struct {
    int addr;
    int exp;
  } rd_t;

  st_t  st_q[$];
  rd_t  rd_q[$];
  st_t  st_e;
  rd_t  rd_e;
  int   act;

  logic rd_req   = 1'b0;
  logic rd_req_d = 1'b0;
  logic stat_req = 1'b0;

  char_buf_writer #(.LENGTH(LENGTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .vsync    (vsync),
    .rd_addr  (rd_addr),
    .rd_code  (rd_code),
    .cursor   (cursor),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_req_d <= rd_req;

  // Monitor
  always @(negedge clk) begin
    if (rd_req_d) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_code=%0d with nothing queued", rd_code);
      end else begin
        rd_e = rd_q.pop_front();
        if (rd_code !== 6'(rd_e.exp)) begin
          errors++;
          $display("FAIL rd_code[%0d]: got %0d expected %0d", rd_e.addr, rd_code, rd_e.exp);
        end
      end
    end
    if (stat_req) begin
      while (st_q.size() > 0) begin
        st_e = st_q.pop_front();
        case (st_e.which)
          0:       act = int'(cursor);
          1:       act = int'(overflow);
          default: act = int'(in_ready);
        endcase
        checks++;
        if (act != st_e.exp) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d", st_e.name, act, st_e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int   n;
    logic hs;
    n        = 0;
    in_data  = b;
    in_valid = 1'b1;
    do begin
      hs = in_ready;
      tick();
      n++;
    end while (!hs && n < 200);
    in_valid = 1'b0;
    if (!hs) check_val("send_timeout", 0, 1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic expect_status(input int cur, input int ovf, input int rdy);
    st_q.push_back('{"cursor", 0, cur});
    st_q.push_back('{"overflow", 1, ovf});
    st_q.push_back('{"in_ready", 2, rdy});
    stat_req = 1'b1;
    tick();
    stat_req = 1'b0;
  endtask

  task automatic read_exp(input int a, input int e);
    rd_q.push_back('{a, e});
    rd_addr = 8'(a);
    rd_req  = 1'b1;
    tick();
    rd_req  = 1'b0;
  endtask

  // Raise vsync from the current (WAIT_VS) cycle and count cycles until
  // in_ready returns: one detect cycle plus LENGTH copy cycles.
  task automatic pulse_and_wait();
    int n;
    n     = 0;
    vsync = 1'b1;
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (n == 2) vsync = 1'b0;
    end
    vsync = 1'b0;
    check_val("commit_latency", n, LENGTH + 1);
  endtask

  task automatic commit();
    send(8'h0A);
    pulse_and_wait();
  endtask

  int hw_exp[LENGTH] = '{18, 15, 22, 22, 25, 0, 33, 25, 28, 22, 14};

  initial begin
    int n;

    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    expect_status(0, 0, 1);
    read_exp(0, 0);
    read_exp(10, 0);
    read_exp(11, 0);
    read_exp(255, 0);

    // "hello world" + newline, then commit
    send_str("hello world");
    expect_status(11, 0, 1);
    send(8'h0A);
    expect_status(11, 0, 0);
    read_exp(0, 0);
    pulse_and_wait();
    expect_status(0, 0, 1);
    for (int i = 0; i < LENGTH; i++) read_exp(i, hw_exp[i]);
    read_exp(11, 0);

    // Overflow: 12th printable byte dropped
    send_str("ABCDEFGHIJKL");
    expect_status(11, 1, 1);
    commit();
    expect_status(0, 0, 1);
    read_exp(0, 11);
    read_exp(5, 16);
    read_exp(10, 21);

    // Backspace, including one at cursor 0
    send_str("ab");
    expect_status(2, 0, 1);
    send(8'h08);
    send(8'h08);
    send(8'h08);
    expect_status(0, 0, 1);
    commit();
    read_exp(0, 0);
    read_exp(1, 0);
    read_exp(2, 13);

    // Mapping corners and ignored control bytes
    send_str("09~");
    send(8'h80);
    send(8'h01);
    send(8'h7F);
    send(8'h0D);
    send_str("Zz");
    expect_status(6, 0, 1);
    commit();
    read_exp(0, 1);
    read_exp(1, 10);
    read_exp(2, 37);
    read_exp(3, 37);
    read_exp(4, 36);
    read_exp(5, 36);
    read_exp(6, 17);

    // Newline while vsync already high: no commit until a fresh edge
    send_str("x");
    vsync = 1'b1;
    repeat (3) tick();
    send(8'h0A);
    repeat (20) tick();
    expect_status(1, 0, 0);
    read_exp(0, 1);
    vsync = 1'b0;
    repeat (2) tick();
    expect_status(1, 0, 0);
    pulse_and_wait();
    expect_status(0, 0, 1);
    read_exp(0, 34);

    // Form feed after a full line
    send_str("hello world");
    expect_status(11, 0, 1);
    send(8'h0C);
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check_val("clear_cycles", n, LENGTH);
    expect_status(0, 0, 1);
    read_exp(0, 34);
    read_exp(1, 10);
    commit();
    read_exp(0, 0);
    read_exp(5, 0);
    read_exp(10, 0);

    // Reset during COPY
    send_str("abc");
    commit();
    read_exp(0, 11);
    tick();
    send_str("q");
    send(8'h0A);
    vsync = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    vsync = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    expect_status(0, 0, 1);
    for (int i = 0; i < LENGTH; i++) read_exp(i, 0);
    read_exp(200, 0);

    repeat (3) tick();
    if (rd_q.size() != 0 || st_q.size() != 0)
      check_val("queues_drained", rd_q.size() + st_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
